// File: rtl/piton_aws_axil_stream_bridge_if.sv
// AXI4-Lite bus between the host register slice and the stream bridge.
// master = host side, slave = bridge side.
interface piton_aws_axil_stream_bridge_if;
   logic        awvalid;
   logic [31:0] awaddr;
   logic        awready;
   logic        wvalid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wready;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;
   logic        arvalid;
   logic [31:0] araddr;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/piton_aws_axil_stream_bridge.sv
// AXI4-Lite slave giving the host NUM_CH stream channels, each with a TX FIFO
// (host->fabric) and an RX FIFO (fabric->host), plus status/control registers.
module piton_aws_axil_stream_bridge #(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 12
) (
   input  logic                         clk,
   input  logic                         sync_rst_n,
   piton_aws_axil_stream_bridge_if.slave s,
   output logic [NUM_CH-1:0]            tx_valid,
   output logic [NUM_CH*DATA_W-1:0]     tx_data,
   input  logic [NUM_CH-1:0]            tx_ready,
   input  logic [NUM_CH-1:0]            rx_valid,
   input  logic [NUM_CH*DATA_W-1:0]     rx_data,
   output logic [NUM_CH-1:0]            rx_ready
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CH_W  = ADDR_W - 4;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_CH-1:0] oh;
      for (int i = 0; i < NUM_CH; i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

   function automatic logic [31:0] status_word(input logic tf, input logic te, input logic rf,
                                               input logic re, input logic [CNT_W-1:0] cnt);
      logic [7:0] sat;
      if (32'(cnt) > 32'd255) begin
         sat = 8'hFF;
      end else begin
         sat = 8'(cnt);
      end
      return {8'h00, sat, 12'h000, re, rf, te, tf};
   endfunction

   w_state_t w_state_r, w_state_n;
   r_state_t r_state_r, r_state_n;
   logic        awready_r, awready_n, wready_r, wready_n, bvalid_r, bvalid_n;
   logic [1:0]  bresp_r, bresp_n;
   logic        aw_held_r, w_held_r;
   logic [31:0] awaddr_r, wdata_r;
   logic [3:0]  wstrb_r;
   logic        arready_r, arready_n, rvalid_r, rvalid_n;
   logic [31:0] rdata_r, rdata_n;
   logic [1:0]  rresp_r, rresp_n;
   logic [NUM_CH-1:0] loopback_r;

   logic              aw_fire_s, w_fire_s, aw_have_s, w_have_s, wr_commit_s, rd_accept_s;
   logic [31:0]       wr_addr_s, wr_data_s, rd_addr_s, rd_data_s;
   logic [3:0]        wr_strb_s, wr_off_s, rd_off_s;
   logic [CH_W-1:0]   wr_ch_s, rd_ch_s;
   logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
   logic              wr_ch_ok_s, rd_ch_ok_s;
   logic [1:0]        wr_resp_s, rd_resp_s;
   logic [NUM_CH-1:0] tx_sel_s, ctrl_sel_s, rx_pop_sel_s;
   logic [NUM_CH-1:0] tx_push_req_s, rx_pop_req_s, lb_we_s, tx_flush_s, rx_flush_s;
   logic [NUM_CH-1:0] tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
   logic [NUM_CH-1:0][DATA_W-1:0] tx_head_s, rx_head_s;
   logic [NUM_CH-1:0][CNT_W-1:0]  rx_cnt_s;
   logic              unused_s;

   assign s.awready = awready_r;
   assign s.wready  = wready_r;
   assign s.bvalid  = bvalid_r;
   assign s.bresp   = bresp_r;
   assign s.arready = arready_r;
   assign s.rvalid  = rvalid_r;
   assign s.rdata   = rdata_r;
   assign s.rresp   = rresp_r;

   // A beat counts as present if captured earlier or handshaking this cycle.
   assign aw_fire_s   = s.awvalid && awready_r;
   assign w_fire_s    = s.wvalid && wready_r;
   assign aw_have_s   = aw_held_r || aw_fire_s;
   assign w_have_s    = w_held_r || w_fire_s;
   assign wr_commit_s = (w_state_r == W_IDLE) && aw_have_s && w_have_s;
   assign wr_addr_s   = aw_held_r ? awaddr_r : s.awaddr;
   assign wr_data_s   = w_held_r ? wdata_r : s.wdata;
   assign wr_strb_s   = w_held_r ? wstrb_r : s.wstrb;
   assign wr_off_s    = wr_addr_s[3:0];
   assign wr_ch_s     = wr_addr_s[ADDR_W-1:4];
   assign wr_idx_s    = wr_ch_s[IDX_W-1:0];
   assign wr_ch_ok_s  = 32'(wr_ch_s) < 32'(NUM_CH);

   assign rd_accept_s = arready_r && s.arvalid;
   assign rd_addr_s   = s.araddr;
   assign rd_off_s    = rd_addr_s[3:0];
   assign rd_ch_s     = rd_addr_s[ADDR_W-1:4];
   assign rd_idx_s    = rd_ch_s[IDX_W-1:0];
   assign rd_ch_ok_s  = 32'(rd_ch_s) < 32'(NUM_CH);

   assign tx_push_req_s = tx_sel_s & {NUM_CH{wr_commit_s}};
   assign lb_we_s       = ctrl_sel_s & {NUM_CH{wr_commit_s}};
   assign tx_flush_s    = lb_we_s & {NUM_CH{wr_data_s[0]}};
   assign rx_flush_s    = lb_we_s & {NUM_CH{wr_data_s[1]}};
   assign rx_pop_req_s  = rx_pop_sel_s & {NUM_CH{rd_accept_s}};

   assign tx_valid = ~loopback_r & ~tx_empty_s;
   assign tx_data  = tx_head_s;
   assign rx_ready = ~loopback_r & ~rx_full_s;
   assign unused_s = ^{wr_addr_s, wr_data_s, rd_addr_s};

   // Write-side register decode; only acted on in the commit cycle.
   always_comb begin
      wr_resp_s  = RESP_SLVERR;
      tx_sel_s   = {NUM_CH{1'b0}};
      ctrl_sel_s = {NUM_CH{1'b0}};
      if (!wr_ch_ok_s) begin
         wr_resp_s = RESP_DECERR;
      end else begin
         case (wr_off_s)
            4'h0: begin
               if (tx_full_s[wr_idx_s]) begin
                  wr_resp_s = RESP_SLVERR;
               end else begin
                  wr_resp_s = RESP_OKAY;
                  if (wr_strb_s != 4'h0) begin
                     tx_sel_s = ch_onehot(wr_idx_s);
                  end else begin
                     tx_sel_s = {NUM_CH{1'b0}};
                  end
               end
            end
            4'hC: begin
               wr_resp_s  = RESP_OKAY;
               ctrl_sel_s = ch_onehot(wr_idx_s);
            end
            default: wr_resp_s = RESP_SLVERR;
         endcase
      end
   end

   // Write FSM next state: collect AW and W independently, then respond.
   always_comb begin
      w_state_n = w_state_r;
      awready_n = awready_r;
      wready_n  = wready_r;
      bvalid_n  = bvalid_r;
      bresp_n   = bresp_r;
      case (w_state_r)
         W_IDLE: begin
            if (wr_commit_s) begin
               w_state_n = W_RESP;
               awready_n = 1'b0;
               wready_n  = 1'b0;
               bvalid_n  = 1'b1;
               bresp_n   = wr_resp_s;
            end else begin
               awready_n = !aw_have_s;
               wready_n  = !w_have_s;
            end
         end
         W_RESP: begin
            if (s.bready) begin
               w_state_n = W_IDLE;
               awready_n = 1'b1;
               wready_n  = 1'b1;
               bvalid_n  = 1'b0;
            end else begin
               bvalid_n  = 1'b1;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
   end

   // Read decode: response data and which RX FIFO (if any) pops.
   always_comb begin
      rd_data_s    = 32'h0000_0000;
      rd_resp_s    = RESP_OKAY;
      rx_pop_sel_s = {NUM_CH{1'b0}};
      if (!rd_ch_ok_s) begin
         rd_resp_s = RESP_DECERR;
      end else begin
         case (rd_off_s)
            4'h4: begin
               if (rx_empty_s[rd_idx_s]) begin
                  rd_resp_s = RESP_SLVERR;
               end else begin
                  rd_data_s    = 32'(rx_head_s[rd_idx_s]);
                  rx_pop_sel_s = ch_onehot(rd_idx_s);
               end
            end
            4'h8: rd_data_s = status_word(tx_full_s[rd_idx_s], tx_empty_s[rd_idx_s],
                                          rx_full_s[rd_idx_s], rx_empty_s[rd_idx_s],
                                          rx_cnt_s[rd_idx_s]);
            4'hC: rd_data_s = {29'h0000_0000, loopback_r[rd_idx_s], 2'b00};
            default: rd_resp_s = RESP_SLVERR;
         endcase
      end
   end

   // Read FSM next state.
   always_comb begin
      r_state_n = r_state_r;
      arready_n = arready_r;
      rvalid_n  = rvalid_r;
      rdata_n   = rdata_r;
      rresp_n   = rresp_r;
      case (r_state_r)
         R_IDLE: begin
            if (s.arvalid) begin
               r_state_n = R_DATA;
               arready_n = 1'b0;
               rvalid_n  = 1'b1;
               rdata_n   = rd_data_s;
               rresp_n   = rd_resp_s;
            end else begin
               arready_n = 1'b1;
            end
         end
         R_DATA: begin
            if (s.rready) begin
               r_state_n = R_IDLE;
               arready_n = 1'b1;
               rvalid_n  = 1'b0;
            end else begin
               rvalid_n  = 1'b1;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
   end

   // AXI-side state registers and per-channel loopback bits.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         w_state_r  <= W_IDLE;
         awready_r  <= 1'b1;
         wready_r   <= 1'b1;
         bvalid_r   <= 1'b0;
         bresp_r    <= RESP_OKAY;
         aw_held_r  <= 1'b0;
         w_held_r   <= 1'b0;
         awaddr_r   <= 32'h0000_0000;
         wdata_r    <= 32'h0000_0000;
         wstrb_r    <= 4'h0;
         r_state_r  <= R_IDLE;
         arready_r  <= 1'b1;
         rvalid_r   <= 1'b0;
         rdata_r    <= 32'h0000_0000;
         rresp_r    <= RESP_OKAY;
         loopback_r <= {NUM_CH{1'b0}};
      end else begin
         w_state_r  <= w_state_n;
         awready_r  <= awready_n;
         wready_r   <= wready_n;
         bvalid_r   <= bvalid_n;
         bresp_r    <= bresp_n;
         aw_held_r  <= aw_have_s && !wr_commit_s;
         w_held_r   <= w_have_s && !wr_commit_s;
         if (aw_fire_s) awaddr_r <= s.awaddr;
         if (w_fire_s) begin
            wdata_r <= s.wdata;
            wstrb_r <= s.wstrb;
         end
         r_state_r  <= r_state_n;
         arready_r  <= arready_n;
         rvalid_r   <= rvalid_n;
         rdata_r    <= rdata_n;
         rresp_r    <= rresp_n;
         loopback_r <= (loopback_r & ~lb_we_s) | (lb_we_s & {NUM_CH{wr_data_s[2]}});
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-1:0] tx_mem_r [FIFO_DEPTH];
      logic [DATA_W-1:0] rx_mem_r [FIFO_DEPTH];
      logic [PTR_W-1:0]  tx_wp_r, tx_rp_r, rx_wp_r, rx_rp_r;
      logic [CNT_W-1:0]  tx_cnt_r, rx_cnt_r;
      logic              lb_move_s, tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
      logic [DATA_W-1:0] rx_in_s;

      assign tx_full_s[c]  = (tx_cnt_r == CNT_W'(FIFO_DEPTH));
      assign tx_empty_s[c] = (tx_cnt_r == CNT_W'(0));
      assign rx_full_s[c]  = (rx_cnt_r == CNT_W'(FIFO_DEPTH));
      assign rx_empty_s[c] = (rx_cnt_r == CNT_W'(0));
      assign tx_head_s[c]  = tx_mem_r[tx_rp_r];
      assign rx_head_s[c]  = rx_mem_r[rx_rp_r];
      assign rx_cnt_s[c]   = rx_cnt_r;

      // A flush on either side freezes the loopback transfer for that cycle.
      assign lb_move_s = loopback_r[c] && !tx_empty_s[c] && !rx_full_s[c] &&
                         !tx_flush_s[c] && !rx_flush_s[c];
      assign tx_push_s = tx_push_req_s[c] && !tx_flush_s[c];
      assign tx_pop_s  = !tx_flush_s[c] &&
                         (loopback_r[c] ? lb_move_s : (tx_valid[c] && tx_ready[c]));
      assign rx_push_s = !rx_flush_s[c] &&
                         (loopback_r[c] ? lb_move_s : (rx_valid[c] && !rx_full_s[c]));
      assign rx_pop_s  = rx_pop_req_s[c] && !rx_empty_s[c] && !rx_flush_s[c];
      assign rx_in_s   = loopback_r[c] ? tx_head_s[c] : rx_data[c*DATA_W +: DATA_W];

      // FIFO storage; contents need no reset since pointers/counts gate validity.
      always_ff @(posedge clk) begin
         if (tx_push_s) tx_mem_r[tx_wp_r] <= wr_data_s[DATA_W-1:0];
         if (rx_push_s) rx_mem_r[rx_wp_r] <= rx_in_s;
      end

      // FIFO pointers and occupancy counts.
      always_ff @(posedge clk) begin
         if (!sync_rst_n || tx_flush_s[c]) begin
            tx_wp_r  <= PTR_W'(0);
            tx_rp_r  <= PTR_W'(0);
            tx_cnt_r <= CNT_W'(0);
         end else begin
            if (tx_push_s) tx_wp_r <= tx_wp_r + PTR_W'(1);
            if (tx_pop_s)  tx_rp_r <= tx_rp_r + PTR_W'(1);
            case ({tx_push_s, tx_pop_s})
               2'b10:   tx_cnt_r <= tx_cnt_r + CNT_W'(1);
               2'b01:   tx_cnt_r <= tx_cnt_r - CNT_W'(1);
               default: tx_cnt_r <= tx_cnt_r;
            endcase
         end
         if (!sync_rst_n || rx_flush_s[c]) begin
            rx_wp_r  <= PTR_W'(0);
            rx_rp_r  <= PTR_W'(0);
            rx_cnt_r <= CNT_W'(0);
         end else begin
            if (rx_push_s) rx_wp_r <= rx_wp_r + PTR_W'(1);
            if (rx_pop_s)  rx_rp_r <= rx_rp_r + PTR_W'(1);
            case ({rx_push_s, rx_pop_s})
               2'b10:   rx_cnt_r <= rx_cnt_r + CNT_W'(1);
               2'b01:   rx_cnt_r <= rx_cnt_r - CNT_W'(1);
               default: rx_cnt_r <= rx_cnt_r;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_piton_aws_axil_stream_bridge.sv
// Directed self-checking bench for piton_aws_axil_stream_bridge (NUM_CH=4, DATA_W=8, FIFO_DEPTH=16).
module tb_piton_aws_axil_stream_bridge;
   logic        clk = 1'b0;
   logic        sync_rst_n;
   logic [3:0]  tx_valid, tx_ready, rx_valid, rx_ready;
   logic [31:0] tx_data, rx_data;
   int          total = 0;
   int          passed = 0;
   int          failed = 0;

   piton_aws_axil_stream_bridge_if bus ();

   piton_aws_axil_stream_bridge #(
      .NUM_CH(4), .DATA_W(8), .FIFO_DEPTH(16), .ADDR_W(12)
   ) dut (
      .clk(clk), .sync_rst_n(sync_rst_n), .s(bus),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns #1 after the edge on which both AW and W have been accepted.
   task automatic write_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic aw_done, w_done, aw_rdy, w_rdy;
      aw_done = 1'b0;
      w_done  = 1'b0;
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         aw_rdy = bus.awready;
         w_rdy  = bus.wready;
         tick();
         if (bus.awvalid && aw_rdy) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
         if (bus.wvalid && w_rdy) begin w_done = 1'b1; bus.wvalid = 1'b0; end
         if (aw_done && w_done) break;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      chk("wr_handshake", {30'h0, aw_done, w_done}, 32'h3);
   endtask

   task automatic write_resp(output logic [1:0] resp);
      int n;
      n = 0;
      while (!bus.bvalid && n < 20) begin tick(); n++; end
      chk("wr_bvalid", 32'(bus.bvalid), 32'h1);
      resp = bus.bresp;
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] exp_resp);
      logic [1:0] r;
      write_issue(addr, data, 4'hF);
      write_resp(r);
      chk(tag, 32'(r), 32'(exp_resp));
   endtask

   task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      logic done, rdy;
      int n;
      done = 1'b0;
      bus.araddr = addr; bus.arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rdy = bus.arready;
         tick();
         if (rdy) begin done = 1'b1; break; end
      end
      bus.arvalid = 1'b0;
      chk("rd_handshake", 32'(done), 32'h1);
      n = 0;
      while (!bus.rvalid && n < 20) begin tick(); n++; end
      chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
      chk({tag, "_data"}, bus.rdata, exp_data);
      chk({tag, "_resp"}, 32'(bus.rresp), 32'(exp_resp));
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   initial begin
      logic [1:0] r;
      int ok_cnt, bv_cnt;
      sync_rst_n = 1'b0;
      tx_ready = 4'h0; rx_valid = 4'h0; rx_data = 32'h0;
      bus.awvalid = 1'b0; bus.awaddr = 32'h0; bus.wvalid = 1'b0; bus.wdata = 32'h0;
      bus.wstrb = 4'h0; bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = 32'h0;
      bus.rready = 1'b0;
      tick(); tick(); tick();

      // Reset values
      chk("rst_awready", 32'(bus.awready), 32'h1);
      chk("rst_wready", 32'(bus.wready), 32'h1);
      chk("rst_arready", 32'(bus.arready), 32'h1);
      chk("rst_bvalid", 32'(bus.bvalid), 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_rx_ready", 32'(rx_ready), 32'hF);
      sync_rst_n = 1'b1;
      tick();

      // 1: single TX write on ch0 with the fabric ready
      tx_ready = 4'b0001;
      write_issue(32'h000, 32'hA5, 4'hF);
      chk("t1_tx_valid", 32'(tx_valid[0]), 32'h1);
      chk("t1_tx_data", 32'(tx_data[7:0]), 32'hA5);
      write_resp(r);
      chk("t1_bresp", 32'(r), 32'h0);
      chk("t1_popped", 32'(tx_valid[0]), 32'h0);

      // 2: fill ch1 TX, overflow, then drain in order
      ok_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         write_issue(32'h010, 32'h30 + 32'(i), 4'hF);
         write_resp(r);
         if (r == 2'b00) ok_cnt++;
      end
      chk("t2_okay_count", 32'(ok_cnt), 32'd16);
      write_chk("t2_overflow_bresp", 32'h010, 32'hFF, 2'b10);
      read_chk("t2_status", 32'h018, 32'h0000_0009, 2'b00);
      tx_ready[1] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain_valid", 32'(tx_valid[1]), 32'h1);
         chk("t2_drain_data", 32'(tx_data[15:8]), 32'h30 + 32'(i));
         tick();
      end
      chk("t2_drained", 32'(tx_valid[1]), 32'h0);
      tx_ready[1] = 1'b0;

      // 3: RX pushes on ch2, pop them, then underflow
      rx_valid[2] = 1'b1;
      chk("t3_rx_ready", 32'(rx_ready[2]), 32'h1);
      for (int i = 1; i <= 3; i++) begin
         rx_data[23:16] = 8'(i);
         tick();
      end
      rx_valid[2] = 1'b0;
      read_chk("t3_status3", 32'h028, 32'h0003_0002, 2'b00);
      read_chk("t3_rx1", 32'h024, 32'h1, 2'b00);
      read_chk("t3_rx2", 32'h024, 32'h2, 2'b00);
      read_chk("t3_rx3", 32'h024, 32'h3, 2'b00);
      read_chk("t3_rx_empty", 32'h024, 32'h0, 2'b10);
      read_chk("t3_status0", 32'h028, 32'h0000_000A, 2'b00);

      // 4a: AW two cycles before W, bready held low for 5 cycles
      bus.awaddr = 32'h030; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      chk("t4a_awready_low", 32'(bus.awready), 32'h0);
      tick();
      bus.wdata = 32'h5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      chk("t4a_wready_low", 32'(bus.wready), 32'h0);
      bv_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.bvalid) bv_cnt++;
         tick();
      end
      chk("t4a_bvalid_held", 32'(bv_cnt), 32'd5);
      chk("t4a_bresp", 32'(bus.bresp), 32'h0);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      chk("t4a_bvalid_clear", 32'(bus.bvalid), 32'h0);
      chk("t4a_ready_back", {30'h0, bus.awready, bus.wready}, 32'h3);

      // 4b: W before AW
      bus.wdata = 32'h6B; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      chk("t4b_bvalid_early", 32'(bus.bvalid), 32'h0);
      tick();
      bus.awaddr = 32'h030; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      write_resp(r);
      chk("t4b_bresp", 32'(r), 32'h0);
      tx_ready[3] = 1'b1;
      chk("t4_first_valid", 32'(tx_valid[3]), 32'h1);
      chk("t4_first_data", 32'(tx_data[31:24]), 32'h5A);
      tick();
      chk("t4_second_data", 32'(tx_data[31:24]), 32'h6B);
      tick();
      chk("t4_one_push_each", 32'(tx_valid[3]), 32'h0);
      tx_ready[3] = 1'b0;

      // 5: loopback on ch0
      write_chk("t5_ctrl_lb", 32'h00C, 32'h4, 2'b00);
      chk("t5_rx_ready_lb", 32'(rx_ready[0]), 32'h0);
      write_issue(32'h000, 32'h11, 4'hF);
      chk("t5_tx_valid_11", 32'(tx_valid[0]), 32'h0);
      write_resp(r);
      chk("t5_bresp_11", 32'(r), 32'h0);
      write_issue(32'h000, 32'h22, 4'hF);
      chk("t5_tx_valid_22", 32'(tx_valid[0]), 32'h0);
      write_resp(r);
      read_chk("t5_status2", 32'h008, 32'h0002_0002, 2'b00);
      read_chk("t5_rx11", 32'h004, 32'h11, 2'b00);
      read_chk("t5_rx22", 32'h004, 32'h22, 2'b00);
      read_chk("t5_status0", 32'h008, 32'h0000_000A, 2'b00);
      read_chk("t5_ctrl_rd", 32'h00C, 32'h4, 2'b00);

      // 5b: RX flush on ch0
      write_chk("t5b_lb_off", 32'h00C, 32'h0, 2'b00);
      rx_valid[0] = 1'b1;
      rx_data[7:0] = 8'h33;
      tick();
      rx_data[7:0] = 8'h44;
      tick();
      rx_valid[0] = 1'b0;
      read_chk("t5b_status2", 32'h008, 32'h0002_0002, 2'b00);
      write_chk("t5b_flush", 32'h00C, 32'h2, 2'b00);
      read_chk("t5b_status_flushed", 32'h008, 32'h0000_000A, 2'b00);
      read_chk("t5b_ctrl_rd", 32'h00C, 32'h0, 2'b00);

      // 6: decode/slave errors, then reset during a pending response
      read_chk("t6_decerr_rd", 32'h040, 32'h0, 2'b11);
      write_chk("t6_decerr_wr", 32'h040, 32'h12, 2'b11);
      read_chk("t6_rd_txdata", 32'h000, 32'h0, 2'b10);
      write_chk("t6_wr_status", 32'h008, 32'h1, 2'b10);
      write_issue(32'h010, 32'h99, 4'hF);
      chk("t6_pending_bvalid", 32'(bus.bvalid), 32'h1);
      chk("t6_pending_tx", 32'(tx_valid[1]), 32'h1);
      sync_rst_n = 1'b0;
      tick();
      chk("t6_rst_bvalid", 32'(bus.bvalid), 32'h0);
      chk("t6_rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("t6_rst_awready", 32'(bus.awready), 32'h1);
      sync_rst_n = 1'b1;
      tick(); tick();
      chk("t6_no_resp", 32'(bus.bvalid), 32'h0);
      read_chk("t6_status_empty", 32'h018, 32'h0000_000A, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
